io_port: RTL and testbench
==========================

IO_PORT -- requirements
Module: io_port

Interface
REQ-001 Parameter: CLKS_PER_BIT, default 16; clocks per serial bit, legal range 2..1024.
REQ-002 clk  in  1  single clock; all state changes on rising edge.
REQ-003 rst  in  1  asynchronous active-high reset.
REQ-004 inp_data  in  8  character from external keyboard.
REQ-005 inp_valid  in  1  keyboard offers inp_data this cycle.
REQ-006 inp_ready  out  1  port can accept a character; equals ~fgi.
REQ-007 inp_ack  in  1  CPU executed INP (AC <- INPR); clears fgi.
REQ-008 inpr  out  8  input register, read by CPU.
REQ-009 fgi  out  1  input flag; 1 = inpr holds an unread character.
REQ-010 outr_load  in  1  CPU executed OUT; loads OUTR from ac_low.
REQ-011 ac_low  in  8  AC[7:0] from datapath.
REQ-012 fgo  out  1  output flag; 1 = transmitter idle, OUTR may be written.
REQ-013 ien  in  1  CPU interrupt enable.
REQ-014 irq  out  1  interrupt request = ien & (fgi | fgo), combinational.
REQ-015 tx  out  1  serial output line; idle high.
REQ-016 ovr  out  1  sticky overrun; set when outr_load arrives with fgo=0.

Function
REQ-017 Input accept: inp_valid & ~fgi at an edge -> inpr <= inp_data and fgi <= 1 at that edge.
REQ-018 inp_valid while fgi=1 is ignored; inpr holds its value.
REQ-019 inp_ack & fgi -> fgi <= 0; inp_ack with fgi=0 has no effect.
REQ-020 inp_ack and inp_valid in the same cycle with fgi=1: fgi clears, the character is not accepted; it is accepted no earlier than the next cycle.
REQ-021 TX FSM states: IDLE, START, DATA, STOP; 4-bit bit index, counter of width ceil(log2(CLKS_PER_BIT)).
REQ-022 IDLE: tx=1, fgo=1; outr_load -> OUTR <= ac_low, fgo <= 0, enter START with counter=0 at the same edge.
REQ-023 START: tx=0 for exactly CLKS_PER_BIT clocks, then DATA with bit index 0.
REQ-024 DATA: tx=OUTR[index] for CLKS_PER_BIT clocks per bit, LSB first; after bit 7 enter STOP.
REQ-025 STOP: tx=1 for CLKS_PER_BIT clocks; at its last edge fgo <= 1 and FSM enters IDLE.
REQ-026 Frame length: fgo is low for exactly 10*CLKS_PER_BIT clocks after the outr_load edge.
REQ-027 outr_load while fgo=0: OUTR and the frame are unaffected; ovr <= 1; ovr clears only on reset.
REQ-028 outr_load in the cycle fgo returns to 1 is accepted normally (back-to-back frames, no gap cycle).
REQ-029 Input and output paths are independent; simultaneous events on both are all honoured.
REQ-030 tx is driven from a register; no glitches.

Reset
REQ-031 rst=1 asynchronously forces: fgi=0, inpr=0x00, OUTR=0x00, fgo=1, ovr=0, tx=1, FSM=IDLE, counters=0.
REQ-032 Reset mid-frame aborts the frame immediately; tx returns high, no partial stop bit.
REQ-033 After rst deasserts, first valid operation may occur on the next rising edge.

Verification (bench CLKS_PER_BIT=4)
REQ-034 Reset release, ien=1 -> fgo=1, fgi=0, irq=1, tx=1, inp_ready=1.
REQ-035 outr_load, ac_low=0x41 -> tx: 4 clks 0, then bits 1,0,0,0,0,0,1,0 at 4 clks each, then 4 clks 1; fgo low exactly 40 clks, then 1.
REQ-036 inp_valid, inp_data=0x5A -> next edge inpr=0x5A, fgi=1, inp_ready=0; inp_valid with 0x33 -> inpr stays 0x5A; inp_ack -> fgi=0.
REQ-037 Second outr_load (0x7E) at clk 10 of frame 0x41 -> frame 0x41 unchanged, ovr=1; outr_load of 0x7E on the fgo-rise cycle -> new start bit on the next clk.
REQ-038 rst pulse at clk 20 of a frame -> tx=1, fgo=1 immediately; ovr=0; subsequent outr_load 0x55 transmits correctly.
REQ-039 ien=0 with fgi=1, fgo=1 -> irq=0; ien=1 -> irq=1 same cycle.

Source files
------------

// File: rtl/io_port.sv
// Character I/O port: keyboard input register with ready/ack flag and an
// 8N1 serial transmitter with an idle flag, sticky overrun and interrupt request.
module io_port #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] inp_data,
  input  logic       inp_valid,
  output logic       inp_ready,
  input  logic       inp_ack,
  output logic [7:0] inpr,
  output logic       fgi,
  input  logic       outr_load,
  input  logic [7:0] ac_low,
  output logic       fgo,
  input  logic       ien,
  output logic       irq,
  output logic       tx,
  output logic       ovr
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [3:0]      idx_q, idx_d;
  logic [7:0]      outr_q, outr_d;
  logic            tx_q, tx_d;
  logic            fgo_q, fgo_d;
  logic            ovr_q, ovr_d;
  logic            fgi_q, fgi_d;
  logic [7:0]      inpr_q, inpr_d;

  // An ack takes priority over a new character while the flag is set, so the
  // offered character is only taken on a later cycle.
  always_comb begin
    fgi_d  = fgi_q;
    inpr_d = inpr_q;
    if (fgi_q) begin
      if (inp_ack) fgi_d = 1'b0;
    end else if (inp_valid) begin
      fgi_d  = 1'b1;
      inpr_d = inp_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fgi_q  <= 1'b0;
      inpr_q <= 8'h00;
    end else begin
      fgi_q  <= fgi_d;
      inpr_q <= inpr_d;
    end
  end

  // tx_d is the line level for the cycle after the edge, so the serial output
  // comes straight from a flop.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    outr_d  = outr_q;
    tx_d    = tx_q;
    fgo_d   = fgo_q;
    ovr_d   = ovr_q;
    if (outr_load && !fgo_q) ovr_d = 1'b1;
    unique case (state_q)
      S_IDLE: begin
        tx_d  = 1'b1;
        fgo_d = 1'b1;
        if (outr_load) begin
          outr_d  = ac_low;
          fgo_d   = 1'b0;
          cnt_d   = '0;
          tx_d    = 1'b0;
          state_d = S_START;
        end
      end
      S_START: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          idx_d   = 4'd0;
          tx_d    = outr_q[0];
          state_d = S_DATA;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (idx_q == 4'd7) begin
            tx_d    = 1'b1;
            state_d = S_STOP;
          end else begin
            idx_d = idx_q + 4'd1;
            tx_d  = outr_q[idx_q[2:0] + 3'd1];
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_STOP: begin
        tx_d = 1'b1;
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          fgo_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
        fgo_d   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= 4'd0;
      outr_q  <= 8'h00;
      tx_q    <= 1'b1;
      fgo_q   <= 1'b1;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      outr_q  <= outr_d;
      tx_q    <= tx_d;
      fgo_q   <= fgo_d;
      ovr_q   <= ovr_d;
    end
  end

  assign inpr      = inpr_q;
  assign fgi       = fgi_q;
  assign inp_ready = ~fgi_q;
  assign fgo       = fgo_q;
  assign tx        = tx_q;
  assign ovr       = ovr_q;
  assign irq       = ien & (fgi_q | fgo_q);

endmodule

// File: tb/tb_io_port.sv
// Self-checking bench for io_port (CLKS_PER_BIT=4): a frame-offset model checked
// every cycle, plus literal expectations on directed scenarios.
module tb_io_port;

  localparam int CPB = 4;
  localparam int FRAME = 10 * CPB;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] inp_data = 8'h00;
  logic       inp_valid = 1'b0;
  logic       inp_ready;
  logic       inp_ack = 1'b0;
  logic [7:0] inpr;
  logic       fgi;
  logic       outr_load = 1'b0;
  logic [7:0] ac_low = 8'h00;
  logic       fgo;
  logic       ien = 1'b1;
  logic       irq;
  logic       tx;
  logic       ovr;

  int checks = 0;
  int errors = 0;
  bit started = 1'b0;

  io_port #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .rst(rst), .inp_data(inp_data), .inp_valid(inp_valid),
    .inp_ready(inp_ready), .inp_ack(inp_ack), .inpr(inpr), .fgi(fgi),
    .outr_load(outr_load), .ac_low(ac_low), .fgo(fgo), .ien(ien), .irq(irq),
    .tx(tx), .ovr(ovr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a frame is described only by the edge number it was loaded on and
  // its byte; line level and idle flag follow from the offset into the frame.
  int         m_n = 0;
  int         m_L = 0;
  bit         m_busy = 1'b0;
  logic [7:0] m_B = 8'h00;
  bit         m_fgi = 1'b0;
  logic [7:0] m_inpr = 8'h00;
  bit         m_ovr = 1'b0;

  function automatic bit m_fgo_at(input int n);
    return !m_busy || (n - m_L) >= FRAME;
  endfunction

  function automatic logic m_tx_at(input int n);
    int o, slot;
    if (m_fgo_at(n)) return 1'b1;
    o = n - m_L;
    slot = o / CPB;
    if (slot == 0) return 1'b0;
    if (slot == 9) return 1'b1;
    return m_B[slot-1];
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy = 1'b0;
      m_fgi  = 1'b0;
      m_inpr = 8'h00;
      m_ovr  = 1'b0;
      m_B    = 8'h00;
    end else begin
      m_n = m_n + 1;
      if (outr_load) begin
        if (m_fgo_at(m_n - 1)) begin
          m_L = m_n;
          m_B = ac_low;
          m_busy = 1'b1;
        end else begin
          m_ovr = 1'b1;
        end
      end
      if (m_fgi) begin
        if (inp_ack) m_fgi = 1'b0;
      end else if (inp_valid) begin
        m_fgi  = 1'b1;
        m_inpr = inp_data;
      end
    end
  end

  always @(negedge clk) begin
    if (started && !rst) begin
      chk("m_tx", {31'd0, tx}, {31'd0, m_tx_at(m_n)});
      chk("m_fgo", {31'd0, fgo}, {31'd0, m_fgo_at(m_n)});
      chk("m_fgi", {31'd0, fgi}, {31'd0, m_fgi});
      chk("m_inpr", {24'd0, inpr}, {24'd0, m_inpr});
      chk("m_ovr", {31'd0, ovr}, {31'd0, m_ovr});
      chk("m_ready", {31'd0, inp_ready}, {31'd0, ~m_fgi});
      chk("m_irq", {31'd0, irq}, {31'd0, ien & (m_fgi | m_fgo_at(m_n))});
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  int exp41 [10] = '{0, 1, 0, 0, 0, 0, 0, 1, 0, 1};

  initial begin
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    started = 1'b1;
    #1;
    chk("rst_fgo", {31'd0, fgo}, 32'd1);
    chk("rst_fgi", {31'd0, fgi}, 32'd0);
    chk("rst_irq", {31'd0, irq}, 32'd1);
    chk("rst_tx", {31'd0, tx}, 32'd1);
    chk("rst_ready", {31'd0, inp_ready}, 32'd1);
    chk("rst_inpr", {24'd0, inpr}, 32'h00);

    // input register handshake
    inp_valid = 1'b1; inp_data = 8'h5A;
    step();
    inp_valid = 1'b0;
    chk("in_inpr", {24'd0, inpr}, 32'h5A);
    chk("in_fgi", {31'd0, fgi}, 32'd1);
    chk("in_ready", {31'd0, inp_ready}, 32'd0);
    inp_valid = 1'b1; inp_data = 8'h33;
    step();
    inp_valid = 1'b0;
    chk("in_hold", {24'd0, inpr}, 32'h5A);
    inp_ack = 1'b1;
    step();
    inp_ack = 1'b0;
    chk("in_ack", {31'd0, fgi}, 32'd0);
    inp_valid = 1'b1; inp_data = 8'h11;
    step();
    inp_valid = 1'b1; inp_ack = 1'b1; inp_data = 8'h22;
    step();
    inp_ack = 1'b0;
    chk("in_ackvld_fgi", {31'd0, fgi}, 32'd0);
    chk("in_ackvld_inpr", {24'd0, inpr}, 32'h11);
    step();
    inp_valid = 1'b0;
    chk("in_next_fgi", {31'd0, fgi}, 32'd1);
    chk("in_next_inpr", {24'd0, inpr}, 32'h22);

    // frame 0x41 with an overrun attempt at its 10th clock
    outr_load = 1'b1; ac_low = 8'h41;
    step();
    outr_load = 1'b0;
    for (int k = 0; k < FRAME; k++) begin
      @(negedge clk);
      chk($sformatf("f41_tx%0d", k), {31'd0, tx}, exp41[k/CPB]);
      chk($sformatf("f41_fgo%0d", k), {31'd0, fgo}, 32'd0);
      if (k == 9) begin outr_load = 1'b1; ac_low = 8'h7E; end
      if (k == 10) outr_load = 1'b0;
    end
    step();
    chk("f41_fgo_end", {31'd0, fgo}, 32'd1);
    chk("f41_ovr", {31'd0, ovr}, 32'd1);
    outr_load = 1'b1; ac_low = 8'h7E;
    step();
    outr_load = 1'b0;
    chk("b2b_start", {31'd0, tx}, 32'd0);
    chk("b2b_fgo", {31'd0, fgo}, 32'd0);

    // reset 20 clocks into the frame
    repeat (19) step();
    rst = 1'b1;
    #1;
    chk("mid_rst_tx", {31'd0, tx}, 32'd1);
    chk("mid_rst_fgo", {31'd0, fgo}, 32'd1);
    chk("mid_rst_ovr", {31'd0, ovr}, 32'd0);
    @(posedge clk);
    #2 rst = 1'b0;

    // frame 0x55 with a simultaneous input event
    inp_valid = 1'b1; inp_data = 8'hC3;
    outr_load = 1'b1; ac_low = 8'h55;
    step();
    inp_valid = 1'b0; outr_load = 1'b0;
    chk("sim_fgi", {31'd0, fgi}, 32'd1);
    chk("sim_inpr", {24'd0, inpr}, 32'hC3);
    chk("sim_tx", {31'd0, tx}, 32'd0);
    repeat (CPB) step();
    chk("f55_b0", {31'd0, tx}, 32'd1);
    repeat (CPB) step();
    chk("f55_b1", {31'd0, tx}, 32'd0);
    repeat (FRAME - 2 * CPB + 2) step();
    chk("f55_idle", {31'd0, fgo}, 32'd1);

    // interrupt enable gating
    ien = 1'b0;
    #1 chk("irq_off", {31'd0, irq}, 32'd0);
    ien = 1'b1;
    #1 chk("irq_on", {31'd0, irq}, 32'd1);
    repeat (3) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
